// File: rtl/operand_stack_if.sv
// Handshake bundle between the instruction controller/ALU (master) and the operand stack (slave).
// The hwm signal exists only when OPSTACK_HWM_EN is defined.
interface operand_stack_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned DW = $clog2(DEPTH + 1);

  logic             valid;
  logic             pop_en;
  logic             pop_two;
  logic             push_en;
  logic [WIDTH-1:0] push_data;
  logic             err_clr;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef OPSTACK_HWM_EN
  logic [DW-1:0]    hwm;
`endif

  modport master (
    output valid, pop_en, pop_two, push_en, push_data, err_clr,
    input  tos, nos, depth, empty, full, overflow, underflow
`ifdef OPSTACK_HWM_EN
    , input hwm
`endif
  );

  modport slave (
    input  valid, pop_en, pop_two, push_en, push_data, err_clr,
    output tos, nos, depth, empty, full, overflow, underflow
`ifdef OPSTACK_HWM_EN
    , output hwm
`endif
  );
endinterface

// File: rtl/operand_stack.sv
// Operand stack for the stack-machine datapath: pop-one/pop-two plus push per cycle, sticky traps.
// Optional high-water-mark tracking is enabled by defining OPSTACK_HWM_EN.
module operand_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input logic           clk,
  input logic           reset,
  operand_stack_if.slave bus
);
  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned SW = DW + 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [1:0]    np_c;
  logic          nu_c;
  logic [SW-1:0] sum_c;
  logic          unf_c, ovf_c, legal_c, we_c;
  logic [AW-1:0] wr_idx_c;

  // Legality: underflow checked first, overflow only when the pop count is satisfiable.
  always_comb begin
    np_c     = 2'd0;
    nu_c     = bus.valid & bus.push_en;
    if (bus.valid && bus.pop_en) np_c = bus.pop_two ? 2'd2 : 2'd1;
    sum_c    = SW'(sp_q) - SW'(np_c) + SW'(nu_c);
    unf_c    = SW'(np_c) > SW'(sp_q);
    ovf_c    = !unf_c && (sum_c > SW'(DEPTH));
    legal_c  = !unf_c && !ovf_c;
    we_c     = legal_c && nu_c && !reset;
    wr_idx_c = AW'(sp_q - DW'(np_c));
    sp_d     = legal_c ? DW'(sum_c) : sp_q;
    ovf_d    = ovf_c | (ovf_q & ~bus.err_clr);
    unf_d    = unf_c | (unf_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is not reset; popped entries stay until overwritten.
  always_ff @(posedge clk) begin
    if (we_c) mem_q[wr_idx_c] <= bus.push_data;
  end

`ifdef OPSTACK_HWM_EN
  logic [DW-1:0] hwm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hwm_q <= '0;
    end else if (legal_c && (DW'(sum_c) > hwm_q)) begin
      hwm_q <= DW'(sum_c);
    end
  end

  assign bus.hwm = hwm_q;
`endif

  // Top entries are read straight from the array, masked when they do not exist.
  assign bus.tos       = (sp_q >= DW'(1)) ? mem_q[AW'(sp_q - DW'(1))] : '0;
  assign bus.nos       = (sp_q >= DW'(2)) ? mem_q[AW'(sp_q - DW'(2))] : '0;
  assign bus.depth     = sp_q;
  assign bus.empty     = (sp_q == '0);
  assign bus.full      = (sp_q == DW'(DEPTH));
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: doc/operand_stack.md
# operand_stack

Hardware operand stack for the stack-machine datapath, directly downstream of the instruction controller. It consumes the controller's pop/push decisions: `ALUSrc` chooses pop-one or pop-two, `RegWrite` requests a push. It presents the top two entries to the ALU and accepts the result written back. It tracks depth, flags full/empty, and traps overflow/underflow without corrupting state.

## Interface
Parameters:
- `WIDTH`, 32, data word width in bits.
- `DEPTH`, 16, number of stack entries (≥2).

Ports:
- `clk`  input  1  system clock. One clock domain; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `valid`  input  1  the instruction in decode is executing this cycle. No action when low.
- `pop_en`  input  1  the instruction pops operands.
- `pop_two`  input  1  1 = pop two (ALUSrc=0), 0 = pop one (ALUSrc=1). Ignored when `pop_en`=0.
- `push_en`  input  1  the instruction pushes `push_data` (RegWrite).
- `push_data`  input  WIDTH  value to push (ALU or memory result).
- `err_clr`  input  1  clears the sticky error flags.
- `tos`  output  WIDTH  top-of-stack entry; 0 when depth=0.
- `nos`  output  WIDTH  next-on-stack entry; 0 when depth<2.
- `depth`  output  $clog2(DEPTH+1)  current entry count.
- `empty`  output  1  depth==0.
- `full`  output  1  depth==DEPTH.
- `overflow`  output  1  sticky: a push was rejected.
- `underflow`  output  1  sticky: a pop was rejected.
- `hwm`  output  $clog2(DEPTH+1)  high-water mark. Present only with OPSTACK_HWM_EN.

## Operation
- Storage: a register array `mem[0..DEPTH-1]` and a pointer `sp` equal to `depth`. Entry `mem[sp-1]` is TOS.
- Pop count `np` = `valid & pop_en ? (pop_two ? 2 : 1) : 0`. Push count `nu` = `valid & push_en`.
- Legality:
  - Underflow when `np > sp`.
  - Overflow when `sp - np + nu > DEPTH`. This is evaluated only if there is no underflow.
- Legal op:
  - `sp <= sp - np + nu`.
  - If `nu`, `mem[sp-np] <= push_data`.
  - A pop never clears entries; they are only overwritten.
- Illegal op:
  - `sp` and `mem` are unchanged.
  - The matching sticky flag is set.
  - Only one flag is set per cycle; underflow takes priority.
- Pop-and-push in the same cycle is the normal ALU case (e.g. pop two, push one ⇒ net −1). It is legal even when `full`=1.
- `err_clr` clears both flags at the next edge. If a new error occurs in the same cycle, set wins.
- `tos`/`nos` are combinational reads of `mem` indexed by `sp`, masked to 0 when they do not exist.
- Reset values:
  - `sp`=0, `empty`=1, `full`=0.
  - `overflow`=0, `underflow`=0, `hwm`=0.
  - `tos`=`nos`=0.
  - `mem` contents are not reset.
- State: no FSM beyond the pointer. The block is a counter-plus-array with two error latches.

## Timing
- Single-cycle. Inputs are sampled at the rising edge; the new `depth`, `tos`, `nos`, `empty`, `full` and flags are visible immediately after that edge.
- Push-to-TOS latency: 1 cycle. Data pushed at edge N appears on `tos` after edge N.
- `tos`/`nos` have a combinational path from the `sp`/`mem` registers only, not from any input. The controller and ALU may use them in the same cycle they issue `pop_en`.
- Asynchronous `reset` mid-operation aborts any in-flight push and forces all reset values immediately. Deassertion is synchronous to `clk` by the system reset synchronizer.
- Boundaries:
  - Pop-two at depth 1 ⇒ underflow.
  - Push at depth DEPTH with no pop ⇒ overflow.
  - Pop-one+push at DEPTH ⇒ legal, depth stays DEPTH, TOS replaced.

## Configuration
- `OPSTACK_HWM_EN` defined:
  - Adds the `hwm` port and register.
  - After each legal op, `hwm <= max(hwm, new sp)`.
  - `err_clr` does not clear it; only `reset` does.
- Not defined:
  - The `hwm` port and logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then push 0xA, 0xB, 0xC on 3 consecutive cycles ⇒ `depth`=3, `tos`=0xC, `nos`=0xB, `empty`=0.
- From depth 3, pop-two + push 0x17 ⇒ `depth`=2, `tos`=0x17, `nos`=0xA.
- Fill to DEPTH=16, then push 0x55 ⇒ `overflow`=1, `depth`=16, `tos` unchanged. Pop-one+push 0x66 ⇒ legal, `tos`=0x66.
- From depth 1, pop-two ⇒ `underflow`=1, `depth`=1, `tos` unchanged. Assert `err_clr` ⇒ both flags 0 next cycle.
- Pulse `reset` mid-stream at depth 5 with push asserted ⇒ `depth`=0, `tos`=`nos`=0, flags 0 immediately. `hwm`=0 when OPSTACK_HWM_EN is defined.
- With OPSTACK_HWM_EN defined: push to depth 7, pop to 2 ⇒ `hwm`=7.
